// File: rtl/l4_pkg.sv
// rtl/l4_pkg.sv - opcodes and FSM state encoding for the l4 processor core
package l4_pkg;
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_DISP = 3'b100;
    localparam logic [2:0] OP_RSVD = 3'b101;
    localparam logic [2:0] OP_SUBI = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_t;
endpackage

// File: rtl/l4_proc_core_if.sv
// rtl/l4_proc_core_if.sv - instruction handshake, status and debug bus of the l4 core
interface l4_proc_core_if #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4
);
    localparam int REG_AW = $clog2(NREGS);

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [REG_AW-1:0] instr_rx;
    logic [REG_AW-1:0] instr_ry;
    logic [DATA_W-1:0] instr_imm;
    logic              done;
    logic              busy;
    logic [DATA_W-1:0] dp_out;
    logic              flag_c;
    logic              flag_z;
    logic              illegal;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr_valid, instr_op, instr_rx, instr_ry, instr_imm, dbg_addr,
        input  instr_ready, done, busy, dp_out, flag_c, flag_z, illegal, dbg_data
    );

    modport slave (
        input  instr_valid, instr_op, instr_rx, instr_ry, instr_imm, dbg_addr,
        output instr_ready, done, busy, dp_out, flag_c, flag_z, illegal, dbg_data
    );
endinterface

// File: rtl/l4_regfile.sv
// rtl/l4_regfile.sv - register array with two read ports, a debug read port and one write port
module l4_regfile #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);
    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/l4_proc_core.sv
// rtl/l4_proc_core.sv - multi-cycle core: IR, A/G/DP latches, add/sub unit and control FSM
module l4_proc_core #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    l4_proc_core_if.slave  bus
);
    import l4_pkg::*;

    localparam int REG_AW = $clog2(NREGS);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_op;
    logic [REG_AW-1:0] r_rx;
    logic [REG_AW-1:0] r_ry;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_g;
    logic [DATA_W-1:0] r_dp;
    logic              r_c;
    logic              r_z;

    logic              w_accept;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_ld_a;
    logic              w_ld_g;
    logic              w_ld_dp;
    logic              w_ld_flags;
    logic              w_done;
    logic              w_illegal;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_opb;
    logic              w_sub;
    logic [DATA_W:0]   w_sum;

    l4_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_regfile (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_rx),
        .i_wdata    (w_wdata),
        .i_raddr_a  (r_rx),
        .o_rdata_a  (w_rd_a),
        .i_raddr_b  (r_ry),
        .o_rdata_b  (w_rd_b),
        .i_dbg_addr (bus.dbg_addr),
        .o_dbg_data (bus.dbg_data)
    );

    // Subtraction is A + ~B + 1, so the carry-out reads as "no borrow".
    assign w_sub   = ~r_op[0];
    assign w_opb   = r_op[2] ? r_imm : w_rd_b;
    assign w_sum   = {1'b0, r_a} + {1'b0, w_opb ^ {DATA_W{w_sub}}} + {{DATA_W{1'b0}}, w_sub};
    assign w_accept = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        w_wdata    = r_g;
        w_ld_a     = 1'b0;
        w_ld_g     = 1'b0;
        w_ld_dp    = 1'b0;
        w_ld_flags = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_T1;
            end
            ST_T1: begin
                case (r_op)
                    OP_LOAD: begin
                        w_we    = 1'b1;
                        w_wdata = r_imm;
                        w_done  = 1'b1;
                        w_next  = ST_IDLE;
                    end
                    OP_MOV: begin
                        w_ld_g = 1'b1;
                        w_next = ST_T2;
                    end
                    OP_DISP: begin
                        w_ld_dp = 1'b1;
                        w_done  = 1'b1;
                        w_next  = ST_IDLE;
                    end
                    OP_RSVD: begin
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                        w_next    = ST_IDLE;
                    end
                    default: begin
                        w_ld_a = 1'b1;
                        w_next = ST_T2;
                    end
                endcase
            end
            ST_T2: begin
                if (r_op == OP_MOV) begin
                    w_we   = 1'b1;
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    w_ld_g     = 1'b1;
                    w_ld_flags = 1'b1;
                    w_next     = ST_T3;
                end
            end
            ST_T3: begin
                w_we   = 1'b1;
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_rx  <= '0;
            r_ry  <= '0;
            r_imm <= '0;
            r_a   <= '0;
            r_g   <= '0;
            r_dp  <= '0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.instr_op;
                r_rx  <= bus.instr_rx;
                r_ry  <= bus.instr_ry;
                r_imm <= bus.instr_imm;
            end
            if (w_ld_a)  r_a  <= w_rd_a;
            // G takes R[ry] for mov (T1) and the ALU result for arithmetic (T2).
            if (w_ld_g)  r_g  <= (r_state == ST_T2) ? w_sum[DATA_W-1:0] : w_rd_b;
            if (w_ld_dp) r_dp <= w_rd_a;
            if (w_ld_flags) begin
                r_c <= w_sum[DATA_W];
                r_z <= (w_sum[DATA_W-1:0] == '0);
            end
        end
    end

    assign bus.instr_ready = rst_n && (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = w_done;
    assign bus.illegal     = w_illegal;
    assign bus.dp_out      = r_dp;
    assign bus.flag_c      = r_c;
    assign bus.flag_z      = r_z;
endmodule

// File: tb/tb_l4_proc_core.sv
// tb/tb_l4_proc_core.sv - directed and randomized checks of l4_proc_core against a behavioural model
module tb_l4_proc_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [3:0] m_r [4];
    logic [3:0] m_dp;
    logic       m_c;
    logic       m_z;

    l4_proc_core_if #(.DATA_W(4), .NREGS(4)) bus ();

    l4_proc_core #(.DATA_W(4), .NREGS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [3:0] d);
        bus.dbg_addr = a;
        #1;
        d = bus.dbg_data;
    endtask

    task automatic expect_reg(input string tag, input logic [1:0] a, input logic [3:0] v);
        logic [3:0] d;
        read_reg(a, d);
        check(tag, {28'd0, d}, {28'd0, v});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
        m_dp = 4'd0;
        m_c  = 1'b0;
        m_z  = 1'b0;
    endtask

    function automatic int latency_of(input logic [2:0] op);
        case (op)
            3'd1:    return 2;
            3'd2, 3'd3, 3'd6, 3'd7: return 3;
            default: return 1;
        endcase
    endfunction

    task automatic model_exec(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry,
                              input logic [3:0] imm);
        int a, b, s;
        case (op)
            3'd0: m_r[rx] = imm;
            3'd1: m_r[rx] = m_r[ry];
            3'd4: m_dp = m_r[rx];
            3'd5: ;
            default: begin
                a = int'(m_r[rx]);
                b = (op >= 3'd6) ? int'(imm) : int'(m_r[ry]);
                if (op[0]) begin
                    s = a + b;
                    m_c = (s > 15);
                end else begin
                    s = a - b;
                    m_c = (a >= b);
                end
                m_r[rx] = 4'(s);
                m_z = (4'(s) == 4'd0);
            end
        endcase
    endtask

    task automatic compare_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            expect_reg($sformatf("%s_r%0d", tag, i), 2'(i), m_r[i]);
        end
        check({tag, "_dp"}, {28'd0, bus.dp_out}, {28'd0, m_dp});
        check({tag, "_c"}, {31'd0, bus.flag_c}, {31'd0, m_c});
        check({tag, "_z"}, {31'd0, bus.flag_z}, {31'd0, m_z});
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic [1:0] rx,
                             input logic [1:0] ry, input logic [3:0] imm);
        int   cyc;
        logic got_done;
        logic ill;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rx    = rx;
        bus.instr_ry    = ry;
        bus.instr_imm   = imm;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        cyc = 0;
        got_done = 1'b0;
        ill = 1'b0;
        while (!got_done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            check({tag, "_nready"}, {31'd0, bus.instr_ready}, 32'd0);
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                ill = bus.illegal;
            end else begin
                check({tag, "_ill_early"}, {31'd0, bus.illegal}, 32'd0);
            end
        end
        check({tag, "_latency"}, 32'(cyc), 32'(latency_of(op)));
        check({tag, "_illegal"}, {31'd0, ill}, {31'd0, (op == 3'd5)});
        @(posedge clk);
        #1;
        model_exec(op, rx, ry, imm);
        compare_state(tag);
    endtask

    initial begin
        logic [2:0] rop;
        logic [1:0] rrx, rry;
        logic [3:0] rimm;

        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_rx    = 2'd0;
        bus.instr_ry    = 2'd0;
        bus.instr_imm   = 4'd0;
        bus.dbg_addr    = 2'd0;
        model_reset();

        #25;
        check("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        compare_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {31'd0, bus.instr_ready}, 32'd1);

        run_instr("ld0", 3'd0, 2'd0, 2'd0, 4'd1);
        run_instr("ld1", 3'd0, 2'd1, 2'd0, 4'd2);
        run_instr("ld2", 3'd0, 2'd2, 2'd0, 4'd4);
        run_instr("ld3", 3'd0, 2'd3, 2'd0, 4'd8);
        run_instr("mov", 3'd1, 2'd2, 2'd3, 4'd0);
        expect_reg("prog_r0", 2'd0, 4'd1);
        expect_reg("prog_r1", 2'd1, 4'd2);
        expect_reg("prog_r2", 2'd2, 4'd8);
        expect_reg("prog_r3", 2'd3, 4'd8);

        run_instr("add", 3'd3, 2'd2, 2'd1, 4'd0);
        expect_reg("add_val", 2'd2, 4'd10);
        check("add_c", {31'd0, bus.flag_c}, 32'd0);
        run_instr("sub", 3'd2, 2'd3, 2'd0, 4'd0);
        expect_reg("sub_val", 2'd3, 4'd7);
        check("sub_c", {31'd0, bus.flag_c}, 32'd1);
        run_instr("addi", 3'd7, 2'd3, 2'd0, 4'd8);
        expect_reg("addi_val", 2'd3, 4'd15);
        run_instr("subi", 3'd6, 2'd3, 2'd0, 4'd5);
        expect_reg("subi_val", 2'd3, 4'd10);

        run_instr("wld0", 3'd0, 2'd0, 2'd0, 4'd15);
        run_instr("wrap_add", 3'd7, 2'd0, 2'd0, 4'd1);
        expect_reg("wrap_add_val", 2'd0, 4'd0);
        check("wrap_add_c", {31'd0, bus.flag_c}, 32'd1);
        check("wrap_add_z", {31'd0, bus.flag_z}, 32'd1);
        run_instr("wld1", 3'd0, 2'd1, 2'd0, 4'd0);
        run_instr("wrap_sub", 3'd6, 2'd1, 2'd0, 4'd1);
        expect_reg("wrap_sub_val", 2'd1, 4'd15);
        check("wrap_sub_c", {31'd0, bus.flag_c}, 32'd0);
        check("wrap_sub_z", {31'd0, bus.flag_z}, 32'd0);

        run_instr("disp", 3'd4, 2'd3, 2'd0, 4'd0);
        check("disp_val", {28'd0, bus.dp_out}, 32'd10);
        run_instr("rsvd", 3'd5, 2'd2, 2'd1, 4'd9);

        // Valid held across two instructions: second must wait for the IDLE cycle after done.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'd0;
        bus.instr_rx    = 2'd1;
        bus.instr_imm   = 4'd2;
        @(posedge clk);
        #1;
        bus.instr_op = 3'd3;
        bus.instr_rx = 2'd1;
        bus.instr_ry = 2'd1;
        @(negedge clk);
        check("hs_first_done", {31'd0, bus.done}, 32'd1);
        check("hs_first_nready", {31'd0, bus.instr_ready}, 32'd0);
        @(negedge clk);
        check("hs_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("hs_idle_ready", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("hs_t1_busy", {31'd0, bus.busy}, 32'd1);
        check("hs_t1_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check("hs_t2_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check("hs_t3_done", {31'd0, bus.done}, 32'd1);
        @(posedge clk);
        #1;
        model_exec(3'd0, 2'd1, 2'd0, 4'd2);
        model_exec(3'd3, 2'd1, 2'd1, 4'd0);
        expect_reg("hs_rxry_val", 2'd1, 4'd4);
        compare_state("hs");

        // Reset asserted during T2 of an add.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'd3;
        bus.instr_rx    = 2'd2;
        bus.instr_ry    = 2'd1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        compare_state("mid_rst");
        repeat (2) @(negedge clk);
        check("mid_rst_hold_ready", {31'd0, bus.instr_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_rel_ready", {31'd0, bus.instr_ready}, 32'd1);

        for (int k = 0; k < 60; k++) begin
            rop  = 3'($urandom_range(0, 7));
            rrx  = 2'($urandom_range(0, 3));
            rry  = 2'($urandom_range(0, 3));
            rimm = 4'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", k), rop, rrx, rry, rimm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/l4_proc_core.md
Name: l4_proc_core

Overview:
- Parametrised successor to the lab-3 multi-cycle datapath and controller.
- Integrates the register file, A/G/DP latches, operand mux, add/sub unit and the control FSM into one core with a valid/ready instruction handshake.
- Adds generalised data width and register count, carry/zero flags, a done pulse, an illegal-opcode flag, and a debug read port.
- Sits between an instruction source (testbench or switch front-end) and the display logic, which consumes dp_out.

Parameters:
- DATA_W, 4, width of registers, immediate, A/G/DP and ALU.
- NREGS, 4, number of general registers; power of two, >=2.
- REG_AW, $clog2(NREGS), register address width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered this cycle.
- instr_ready  out  1  core can accept; high only in IDLE with rst_n high.
- instr_op  in  3  opcode.
- instr_rx  in  REG_AW  destination/first source register.
- instr_ry  in  REG_AW  second source register.
- instr_imm  in  DATA_W  immediate.
- done  out  1  one-cycle pulse in the final execute cycle of each instruction.
- busy  out  1  high while state != IDLE.
- dp_out  out  DATA_W  display latch contents.
- flag_c  out  1  carry (add) / no-borrow (sub) from the last arithmetic op.
- flag_z  out  1  result==0 from the last arithmetic op.
- illegal  out  1  one-cycle pulse on a reserved opcode.
- dbg_addr  in  REG_AW  debug register select.
- dbg_data  out  DATA_W  combinational R[dbg_addr].

Behaviour:
- Reset (async, rst_n low): all R[i], A, G, DP and IR cleared to 0. flag_c, flag_z, done and illegal are 0. State is IDLE, and instr_ready is forced to 0 while rst_n is low.
- Handshake: an instruction is accepted on a rising edge with instr_valid && instr_ready, which latches op, rx, ry and imm into IR. Inputs are ignored in every other state.
- FSM states: IDLE, T1, T2, T3. Accept moves IDLE to T1. The state that asserts done returns to IDLE on the next edge.
- Back-to-back: after done the core is in IDLE for at least one cycle, so the minimum issue interval is latency+1.
- Opcodes and cycle behaviour, from IR:
  - 000 load: T1 writes R[rx] <= imm; done. Latency 1.
  - 001 mov: T1 loads G <= R[ry]; T2 writes R[rx] <= G; done. Latency 2.
  - 011 add / 010 sub: T1 loads A <= R[rx]. T2 computes G <= A +/- R[ry] and updates the flags. T3 writes R[rx] <= G; done. Latency 3.
  - 111 addi / 110 subi: same as add/sub with imm replacing R[ry] in T2. Latency 3.
  - 100 disp: T1 loads DP <= R[rx]; done. Latency 1.
  - 101 reserved: T1 pulses illegal together with done; no state change. Latency 1.
- Arithmetic: results wrap modulo 2^DATA_W.
  - add: flag_c = carry-out.
  - sub: computed as A + ~B + 1; flag_c = carry-out, so 1 means no borrow.
  - flag_z = (G result == 0).
  - Flags change only in T2 of arithmetic ops and hold otherwise.
- rx == ry is legal: A captures the old value in T1, the operand read in T2 returns the old value, and the write happens in T3.
- R0 is an ordinary writable register.
- Reset mid-instruction aborts immediately; no partial write survives, because reset clears everything.
- dbg_data is a combinational read of the register array and does not disturb execution.

Decomposition:
- Package l4_pkg holds:
  - opcode localparams OP_LOAD, OP_MOV, OP_SUB, OP_ADD, OP_DISP, OP_RSVD, OP_SUBI, OP_ADDI;
  - the state enum/encoding for IDLE, T1, T2, T3.
- Sub-module l4_regfile: parametrised, two combinational read ports plus a debug read port, one synchronous write port, async active-low clear.
- FSM, A/G/DP latches, operand mux and ALU stay in l4_proc_core.

Test Plan:
- Load program: load r0=1, r1=2, r2=4, r3=8, then mov r2<-r3. Required: dbg r0..r3 = 1,2,8,8; done after 1 cycle per load and 2 for mov; instr_ready low while busy.
- Arithmetic: add r2=r2+r1 gives 10, c=0, z=0. sub r3=r3-r0 gives 7, c=1. addi r3+8 gives 15. subi r3-5 gives 10. Each op asserts done in the 3rd execute cycle.
- Wrap and flags: load r0=15, addi r0+1 gives r0=0, c=1, z=1. Then load r1=0, subi r1-1 gives 15, c=0, z=0.
- Display and illegal: disp r3 (r3=10) gives dp_out=10 after 1 cycle. Opcode 101 gives one illegal pulse with done, and registers and flags unchanged.
- Handshake: hold instr_valid high across two instructions. Required: the second is accepted only on the edge after done's IDLE cycle, never while busy. rx==ry add r1=r1+r1 with r1=2 gives 4.
- Reset: assert rst_n low during T2 of an add. Required: outputs and all registers read 0 immediately, state IDLE, instr_ready 0 until rst_n rises and 1 thereafter.
